// File: rtl/bias_add_stage.sv
// Bias-add stage: per-lane signed add of bias to adder-tree sums, 18-bit saturation,
// two-deep valid/ready pipeline with end-of-pass marker. Optional ReLU via BIAS_ADD_RELU_EN.
module bias_add_stage #(
   parameter int unsigned N_adder_tree = 16,
   parameter int unsigned DW           = 18,
   parameter int unsigned N_OUT        = 64
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [N_adder_tree*DW-1:0]   bias_q,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [N_adder_tree*DW-1:0]   in_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [N_adder_tree*DW-1:0]   out_data,
   output logic                         out_last,
   output logic                         sat_flag
);

   localparam int unsigned SW = DW + 1;
   localparam int unsigned VW = N_adder_tree * DW;
   localparam int unsigned CW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(N_OUT - 1);

   logic                             s1_valid;
   logic [N_adder_tree-1:0][SW-1:0]  s1_sum;
   logic [N_adder_tree-1:0][SW-1:0]  sum_c;
   logic [VW-1:0]                    sat_c;
   logic                             sat_any_c;
   logic                             s1_load;
   logic                             s2_load;
   logic                             xfer;
   logic [CW-1:0]                    cnt;
   logic [CW-1:0]                    cnt_next;

   // Handshake: stage 1 frees up whenever stage 2 can take its contents.
   assign s2_load  = s1_valid && (!out_valid || out_ready);
   assign in_ready = !s1_valid || !out_valid || out_ready;
   assign s1_load  = in_valid && in_ready;
   assign xfer     = out_valid && out_ready;

   // One guard bit per lane keeps the raw sum exact before clamping.
   always_comb begin
      sum_c = '0;
      for (int i = 0; i < int'(N_adder_tree); i++) begin
         sum_c[i] = {in_data[DW*i+DW-1], in_data[DW*i +: DW]}
                  + {bias_q[DW*i+DW-1], bias_q[DW*i +: DW]};
      end
   end

   // Overflow shows as guard bit differing from the lane sign bit.
   always_comb begin
      sat_c     = '0;
      sat_any_c = 1'b0;
      for (int i = 0; i < int'(N_adder_tree); i++) begin
         if (s1_sum[i][SW-1] != s1_sum[i][SW-2]) begin
            sat_any_c = 1'b1;
            sat_c[DW*i +: DW] = s1_sum[i][SW-1] ? {1'b1, {(DW-1){1'b0}}}
                                                : {1'b0, {(DW-1){1'b1}}};
         end else begin
            sat_c[DW*i +: DW] = s1_sum[i][DW-1:0];
         end
`ifdef BIAS_ADD_RELU_EN
         if (sat_c[DW*i+DW-1]) begin
            sat_c[DW*i +: DW] = '0;
         end
`endif
      end
   end

   always_comb begin
      cnt_next = cnt;
      if (xfer) begin
         cnt_next = (cnt == LAST_CNT) ? '0 : cnt + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid  <= 1'b0;
         s1_sum    <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
         sat_flag  <= 1'b0;
         cnt       <= '0;
      end else begin
         if (s1_load) begin
            s1_sum <= sum_c;
         end
         s1_valid  <= s1_load || (s1_valid && !s2_load);
         out_valid <= s2_load || (out_valid && !out_ready);
         if (s2_load) begin
            out_data <= sat_c;
            out_last <= (cnt_next == LAST_CNT);
         end else if (xfer) begin
            out_last <= 1'b0;
         end
         if (s2_load && sat_any_c) begin
            sat_flag <= 1'b1;
         end
         cnt <= cnt_next;
      end
   end

endmodule
